// File: rtl/move_scheduler_if.sv
// ---------------------------------------------------------------------------
// move_scheduler_if
// Groups the three handshakes around the move scheduler:
//   usr_valid/usr_move/usr_ready  user move offered to the scheduler
//   mv_valid/mv_code/mv_ack       move presented to the cube-state logic
//   draw_start/draw_done          redraw request to cube_drawer
// Move encoding: [3:1] face 0..5 (front,back,left,right,top,bottom),
//                [0] 0=CW, 1=CCW.
// master: the scheduler side.  slave: the board / logic / drawer side.
// ---------------------------------------------------------------------------
interface move_scheduler_if;
    logic       usr_valid;
    logic [3:0] usr_move;
    logic       usr_ready;
    logic       mv_valid;
    logic [3:0] mv_code;
    logic       mv_ack;
    logic       draw_start;
    logic       draw_done;

    modport master (
        input  usr_valid, usr_move, mv_ack, draw_done,
        output usr_ready, mv_valid, mv_code, draw_start
    );

    modport slave (
        output usr_valid, usr_move, mv_ack, draw_done,
        input  usr_ready, mv_valid, mv_code, draw_start
    );
endinterface

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
// Merges user moves and LFSR scramble moves into one in-order move FIFO,
// issues moves one at a time to the cube-state logic and requests redraws.
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset; flushes FIFO and FSM
//   bus          move_scheduler_if.master (user / move / draw handshakes)
//   scr_start    one-cycle pulse: start a scramble of SCR_LEN moves
//   scr_active   scramble generation in progress
//   bad_move     one-cycle pulse: a user move with face 6/7 was dropped
//   fifo_count   entries queued
//   busy         not idle, FIFO non-empty, or scrambling
// ---------------------------------------------------------------------------
module move_scheduler #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SCR_LEN     = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          REDRAW_EACH = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    move_scheduler_if.master              bus,
    input  logic                          scr_start,
    output logic                          scr_active,
    output logic                          bad_move,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] BOOT      = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] DRAW_REQ  = 3'd3;
    localparam logic [2:0] DRAW_WAIT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          scr_active_q, scr_active_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [3:0]    prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic          bad_q, bad_d;

    logic          full, usr_fire, scr_push, push, pop, cand_inv;
    logic [3:0]    cand, push_data;

    // Galois LFSR step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign full          = (count_q == DEPTH_C);
    assign bus.usr_ready = !full && !scr_active_q;
    assign usr_fire      = bus.usr_valid && bus.usr_ready;

    assign cand     = lfsr_q[3:0];
    assign cand_inv = prev_vld_q && (cand[3:1] == prev_q[3:1]) && (cand[0] != prev_q[0]);
    assign scr_push = scr_active_q && (cand[3:1] <= 3'd5) && !full && !cand_inv;

    // usr_ready is low while scrambling, so the two sources never collide.
    assign push      = (usr_fire && (bus.usr_move[3:1] <= 3'd5)) || scr_push;
    assign push_data = scr_active_q ? cand : bus.usr_move;
    assign pop       = (state_q == ISSUE) && bus.mv_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        lfsr_d       = lfsr_q;
        scr_active_d = scr_active_q;
        remaining_d  = remaining_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        if (scr_active_q) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (scr_push) begin
                prev_d      = cand;
                prev_vld_d  = 1'b1;
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) scr_active_d = 1'b0;
            end
        end else if (scr_start) begin
            scr_active_d = 1'b1;
            remaining_d  = 8'(SCR_LEN);
            prev_vld_d   = 1'b0;
        end
    end

    assign bad_d = usr_fire && (bus.usr_move[3:1] > 3'd5);

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:      state_d = DRAW_REQ;
            IDLE:      if (count_q != '0) state_d = ISSUE;
            ISSUE:     if (bus.mv_ack)
                           state_d = ((REDRAW_EACH != 0) || (count_d == '0)) ? DRAW_REQ : ISSUE;
            DRAW_REQ:  state_d = DRAW_WAIT;
            DRAW_WAIT: if (bus.draw_done) state_d = IDLE;
            default:   state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= BOOT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            scr_active_q <= 1'b0;
            remaining_q  <= 8'd0;
            prev_q       <= 4'd0;
            prev_vld_q   <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lfsr_q       <= lfsr_d;
            scr_active_q <= scr_active_d;
            remaining_q  <= remaining_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            bad_q        <= bad_d;
        end
    end

    // FIFO storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.mv_valid   = (state_q == ISSUE);
    assign bus.mv_code    = (state_q == ISSUE) ? mem_q[rd_ptr_q] : 4'd0;
    assign bus.draw_start = (state_q == DRAW_REQ);
    assign scr_active     = scr_active_q;
    assign bad_move       = bad_q;
    assign fifo_count     = count_q;
    assign busy           = (state_q != IDLE) || (count_q != '0) || scr_active_q;
endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
    logic clk = 1'b0;
    logic resetn;
    logic scr_start_a, scr_start_b;
    logic a_scr_active, a_bad_move, a_busy;
    logic b_scr_active, b_bad_move, b_busy;
    logic [2:0] a_fifo_count, b_fifo_count;

    int n_total = 0;
    int n_bad   = 0;

    move_scheduler_if ia();
    move_scheduler_if ib();

    always #5 clk = ~clk;

    move_scheduler #(.FIFO_DEPTH(4), .SCR_LEN(20), .LFSR_SEED(16'hACE1), .REDRAW_EACH(1)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ia.master), .scr_start(scr_start_a),
        .scr_active(a_scr_active), .bad_move(a_bad_move), .fifo_count(a_fifo_count), .busy(a_busy)
    );

    move_scheduler #(.FIFO_DEPTH(4), .SCR_LEN(20), .LFSR_SEED(16'hACE1), .REDRAW_EACH(0)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ib.master), .scr_start(scr_start_b),
        .scr_active(b_scr_active), .bad_move(b_bad_move), .fifo_count(b_fifo_count), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] b_codes [4];
    logic [3:0] prev_code, first_code, second_code;
    int n_mv, bad_face, inv_pairs, rdy_err, cycles, draws;

    initial begin
        b_codes[0] = 4'd0;  b_codes[1] = 4'd3;
        b_codes[2] = 4'd5;  b_codes[3] = 4'd10;
        resetn = 1'b0;
        scr_start_a = 1'b0; scr_start_b = 1'b0;
        ia.usr_valid = 1'b0; ia.usr_move = 4'd0; ia.mv_ack = 1'b0; ia.draw_done = 1'b0;
        ib.usr_valid = 1'b0; ib.usr_move = 4'd0; ib.mv_ack = 1'b0; ib.draw_done = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_count", a_fifo_count, 0);
        chk("rst_mv_valid", ia.mv_valid, 0);
        chk("rst_mv_code", ia.mv_code, 0);
        chk("rst_draw_start", ia.draw_start, 0);
        chk("rst_usr_ready", ia.usr_ready, 1);
        chk("rst_busy", a_busy, 1);
        chk("rst_scr_active", a_scr_active, 0);
        chk("rst_bad_move", a_bad_move, 0);

        // Boot redraw
        resetn = 1'b1;
        step();
        chk("boot_draw", ia.draw_start, 1);
        chk("boot_busy", a_busy, 1);
        repeat (4) begin
            step();
            chk("boot_draw_once", ia.draw_start, 0);
        end
        ia.draw_done = 1'b1;
        step();
        ia.draw_done = 1'b0;
        chk("boot_idle_busy", a_busy, 0);
        chk("boot_no_draw", ia.draw_start, 0);

        // Single user move, acked 3 cycles into ISSUE
        chk("u_ready", ia.usr_ready, 1);
        ia.usr_valid = 1'b1; ia.usr_move = 4'b0010;
        step();
        ia.usr_valid = 1'b0;
        chk("u_count1", a_fifo_count, 1);
        chk("u_not_yet", ia.mv_valid, 0);
        step();
        chk("u_valid", ia.mv_valid, 1);
        chk("u_code0", ia.mv_code, 2);
        step();
        chk("u_code1", ia.mv_code, 2);
        step();
        chk("u_code2", ia.mv_code, 2);
        chk("u_hold_count", a_fifo_count, 1);
        ia.mv_ack = 1'b1;
        step();
        ia.mv_ack = 1'b0;
        chk("u_count0", a_fifo_count, 0);
        chk("u_valid_drop", ia.mv_valid, 0);
        chk("u_draw", ia.draw_start, 1);
        step();
        chk("u_draw_once", ia.draw_start, 0);
        ia.draw_done = 1'b1;
        step();
        ia.draw_done = 1'b0;
        chk("u_done_busy", a_busy, 0);

        // Bad face dropped
        ia.usr_valid = 1'b1; ia.usr_move = 4'b1100;
        step();
        ia.usr_valid = 1'b0;
        chk("bad_pulse", a_bad_move, 1);
        chk("bad_count", a_fifo_count, 0);
        chk("bad_no_valid", ia.mv_valid, 0);
        step();
        chk("bad_pulse_end", a_bad_move, 0);
        chk("bad_no_valid2", ia.mv_valid, 0);

        // Scramble of 20 moves; logic and drawer answer at once
        scr_start_a = 1'b1;
        step();
        scr_start_a = 1'b0;
        chk("scr_active", a_scr_active, 1);
        chk("scr_ready_low", ia.usr_ready, 0);
        ia.mv_ack = 1'b1; ia.draw_done = 1'b1;
        n_mv = 0; bad_face = 0; inv_pairs = 0; rdy_err = 0; cycles = 0;
        prev_code = 4'd0; first_code = 4'hF; second_code = 4'hF;
        while (a_busy && cycles < 3000) begin
            if (ia.mv_valid) begin
                if (n_mv == 0) first_code = ia.mv_code;
                if (n_mv == 1) second_code = ia.mv_code;
                if (ia.mv_code[3:1] > 3'd5) bad_face++;
                if (n_mv > 0 && ia.mv_code[3:1] == prev_code[3:1] && ia.mv_code[0] != prev_code[0])
                    inv_pairs++;
                prev_code = ia.mv_code;
                n_mv++;
            end
            if (a_scr_active && ia.usr_ready) rdy_err++;
            step();
            cycles++;
        end
        ia.mv_ack = 1'b0; ia.draw_done = 1'b0;
        chk("scr_moves", n_mv, 20);
        chk("scr_first", first_code, 4'd1);
        chk("scr_second", second_code, 4'd8);
        chk("scr_bad_face", bad_face, 0);
        chk("scr_inverse", inv_pairs, 0);
        chk("scr_ready_err", rdy_err, 0);
        chk("scr_finished", a_busy, 0);
        chk("scr_count0", a_fifo_count, 0);

        // REDRAW_EACH=0: fill FIFO, then drain with one redraw
        ib.draw_done = 1'b0; ib.mv_ack = 1'b0;
        chk("b_idle", b_busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("b_ready", ib.usr_ready, 1);
            ib.usr_valid = 1'b1; ib.usr_move = b_codes[i];
            step();
        end
        ib.usr_valid = 1'b0;
        chk("b_full_ready", ib.usr_ready, 0);
        chk("b_count4", b_fifo_count, 4);
        chk("b_valid", ib.mv_valid, 1);
        chk("b_code0", ib.mv_code, 0);
        draws = 0;
        ib.mv_ack = 1'b1;
        step();
        draws += int'(ib.draw_start);
        chk("b_code1", ib.mv_code, 3);
        chk("b_count3", b_fifo_count, 3);
        step();
        draws += int'(ib.draw_start);
        chk("b_code2", ib.mv_code, 5);
        step();
        draws += int'(ib.draw_start);
        chk("b_code3", ib.mv_code, 10);
        chk("b_count1", b_fifo_count, 1);
        step();
        ib.mv_ack = 1'b0;
        chk("b_drained_valid", ib.mv_valid, 0);
        chk("b_count0", b_fifo_count, 0);
        draws += int'(ib.draw_start);
        repeat (4) begin
            step();
            draws += int'(ib.draw_start);
        end
        chk("b_draws", draws, 1);
        ib.draw_done = 1'b1;
        step();
        chk("b_done_busy", b_busy, 0);
        chk("b_no_scr", b_scr_active, 0);
        chk("b_no_bad", b_bad_move, 0);

        // Reset mid-move with 3 queued
        ia.usr_valid = 1'b1; ia.usr_move = 4'd2;
        step();
        ia.usr_move = 4'd4;
        step();
        ia.usr_move = 4'd6;
        step();
        ia.usr_valid = 1'b0;
        chk("r_count3", a_fifo_count, 3);
        chk("r_valid", ia.mv_valid, 1);
        chk("r_code", ia.mv_code, 2);
        #3;
        resetn = 1'b0;
        #1;
        chk("r_valid_drop", ia.mv_valid, 0);
        chk("r_count_flush", a_fifo_count, 0);
        chk("r_busy", a_busy, 1);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("r_boot_draw", ia.draw_start, 1);
        chk("r_boot_count", a_fifo_count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
